// File: rtl/multiplier_pipe.sv
// multiplier_pipe: pipelined integer multiplier for the mult FU.
// Supports MUL/MULH/MULHU/MULHSU/MULW with a valid/ready result handshake,
// backpressure and per-stage bubble collapse.
// Optional feature macro: MULT_CLMUL_EN adds the Zbc CLMUL/CLMULH/CLMULR ops.
`timescale 1ns/1ps

package multiplier_pipe_pkg;
  typedef enum logic [6:0] {
    ADD    = 7'd0,
    SUB    = 7'd1,
    MUL    = 7'd2,
    MULH   = 7'd3,
    MULHU  = 7'd4,
    MULHSU = 7'd5,
    MULW   = 7'd6,
    DIV    = 7'd7,
    CLMUL  = 7'd8,
    CLMULH = 7'd9,
    CLMULR = 7'd10
  } fu_op;
endpackage

module multiplier_pipe
  import multiplier_pipe_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int NUM_STAGES    = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     mult_valid_i,
  input  fu_op                     operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic                     mult_ready_o,
  output logic [XLEN-1:0]          result_o,
  output logic                     mult_valid_o,
  output logic [TRANS_ID_BITS-1:0] mult_trans_id_o,
  input  logic                     result_ready_i
);

  localparam int LAST = NUM_STAGES - 1;
  localparam int PW   = 2 * XLEN;

  // Operators this build loads into the pipeline; everything else is dropped.
  function automatic logic is_mul_op(input fu_op op);
    logic r;
    case (op)
      MUL, MULH, MULHU, MULHSU, MULW: r = 1'b1;
`ifdef MULT_CLMUL_EN
      CLMUL, CLMULH, CLMULR:          r = 1'b1;
`endif
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef MULT_CLMUL_EN
  function automatic logic is_clmul_op(input fu_op op);
    logic r;
    case (op)
      CLMUL, CLMULH, CLMULR: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  // Carry-less (XOR) product of two XLEN-bit operands.
  function automatic logic [PW-1:0] clmul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [PW-1:0] acc;
    acc = {PW{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      if (b[i]) begin
        acc = acc ^ ({{XLEN{1'b0}}, a} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction
`endif

  // Picks the architectural result out of the full-width product.
  function automatic logic [XLEN-1:0] select_result(input fu_op op, input logic [PW-1:0] p);
    logic [XLEN-1:0] r;
    case (op)
      MULH, MULHU, MULHSU: r = p[PW-1:XLEN];
      MULW:                r = XLEN'($signed(p[31:0]));
`ifdef MULT_CLMUL_EN
      CLMUL:               r = p[XLEN-1:0];
      CLMULH:              r = p[PW-1:XLEN];
      CLMULR:              r = p[PW-2:XLEN-1];
`endif
      default:             r = p[XLEN-1:0];
    endcase
    return r;
  endfunction

  logic                     sign_a_s;
  logic                     sign_b_s;
  logic [PW-1:0]            a_ext_s;
  logic [PW-1:0]            b_ext_s;
  logic [PW-1:0]            mul_prod_s;
  logic [PW-1:0]            stage0_prod_s;
  logic [NUM_STAGES-1:0]    move_s;
  logic                     room_s;
  logic                     accept_s;

  logic [NUM_STAGES-1:0]    valid_r;
  logic [TRANS_ID_BITS-1:0] id_r   [NUM_STAGES];
  fu_op                     op_r   [NUM_STAGES];
  logic [PW-1:0]            prod_r [NUM_STAGES];

  // Operand signedness for the selected operator.
  always_comb begin
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    case (operator_i)
      MULH:    begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
      MULHSU:  begin sign_a_s = 1'b1; sign_b_s = 1'b0; end
      default: begin sign_a_s = 1'b0; sign_b_s = 1'b0; end
    endcase
  end

  // Extending to 2*XLEN bits and keeping the low 2*XLEN product bits equals
  // the (XLEN+1)-bit signed multiply truncated to 2*XLEN bits.
  assign a_ext_s    = {{XLEN{sign_a_s & operand_a_i[XLEN-1]}}, operand_a_i};
  assign b_ext_s    = {{XLEN{sign_b_s & operand_b_i[XLEN-1]}}, operand_b_i};
  assign mul_prod_s = a_ext_s * b_ext_s;

`ifdef MULT_CLMUL_EN
  assign stage0_prod_s = is_clmul_op(operator_i) ? clmul(operand_a_i, operand_b_i) : mul_prod_s;
`else
  assign stage0_prod_s = mul_prod_s;
`endif

  // Per-stage load enable: a stage may load if it is empty or anything downstream can drain.
  always_comb begin
    move_s = {NUM_STAGES{1'b0}};
    room_s = result_ready_i;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      room_s    = room_s || !valid_r[k];
      move_s[k] = room_s;
    end
  end

  assign mult_ready_o = move_s[0];
  assign accept_s     = mult_valid_i && move_s[0] && is_mul_op(operator_i) && !clr_i;

  // Stage valid bits: flush wins, otherwise shift forward and refill bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= {NUM_STAGES{1'b0}};
    end else if (clr_i) begin
      valid_r <= {NUM_STAGES{1'b0}};
    end else begin
      if (move_s[0]) begin
        valid_r[0] <= accept_s;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (move_s[k]) begin
          valid_r[k] <= valid_r[k-1];
        end
      end
    end
  end

  // Stage payload: stage 0 captures accepted ops, later stages copy their predecessor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        id_r[k]   <= {TRANS_ID_BITS{1'b0}};
        op_r[k]   <= ADD;
        prod_r[k] <= {PW{1'b0}};
      end
    end else begin
      if (accept_s) begin
        id_r[0]   <= trans_id_i;
        op_r[0]   <= operator_i;
        prod_r[0] <= stage0_prod_s;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (move_s[k] && valid_r[k-1]) begin
          id_r[k]   <= id_r[k-1];
          op_r[k]   <= op_r[k-1];
          prod_r[k] <= prod_r[k-1];
        end
      end
    end
  end

  assign mult_valid_o    = valid_r[LAST];
  assign mult_trans_id_o = id_r[LAST];
  assign result_o        = select_result(op_r[LAST], prod_r[LAST]);

endmodule

// File: tb/tb_multiplier_pipe.sv
// Directed self-checking bench for multiplier_pipe: a 2-stage instance for
// arithmetic/latency checks and a 3-stage instance for flow-control checks.
// MULT_CLMUL_EN selects the carry-less vectors instead of the rejection check.
`timescale 1ns/1ps

module tb_multiplier_pipe;
  import multiplier_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  int          n_cmp;
  int          n_err;

  logic        clr2, v2, rr2, rdy2, vo2;
  logic [2:0]  id2, ido2;
  fu_op        op2;
  logic [63:0] a2, b2, res2;

  logic        clr3, v3, rr3, rdy3, vo3;
  logic [2:0]  id3, ido3;
  fu_op        op3;
  logic [63:0] a3, b3, res3;

  multiplier_pipe #(.XLEN(64), .NUM_STAGES(2), .TRANS_ID_BITS(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr2), .trans_id_i(id2), .mult_valid_i(v2),
    .operator_i(op2), .operand_a_i(a2), .operand_b_i(b2), .mult_ready_o(rdy2),
    .result_o(res2), .mult_valid_o(vo2), .mult_trans_id_o(ido2), .result_ready_i(rr2)
  );

  multiplier_pipe #(.XLEN(64), .NUM_STAGES(3), .TRANS_ID_BITS(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr3), .trans_id_i(id3), .mult_valid_i(v3),
    .operator_i(op3), .operand_a_i(a3), .operand_b_i(b3), .mult_ready_o(rdy3),
    .result_o(res3), .mult_valid_o(vo3), .mult_trans_id_o(ido3), .result_ready_i(rr3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (vo2 !== 1'b0)       begin n_err++; $display("FAIL reset_valid2: got %b exp 0", vo2); end
    n_cmp++; if (res2 !== 64'd0)     begin n_err++; $display("FAIL reset_result2: got %h exp 0", res2); end
    n_cmp++; if (ido2 !== 3'd0)      begin n_err++; $display("FAIL reset_id2: got %0d exp 0", ido2); end
    n_cmp++; if (vo3 !== 1'b0)       begin n_err++; $display("FAIL reset_valid3: got %b exp 0", vo3); end
    n_cmp++; if (res3 !== 64'd0)     begin n_err++; $display("FAIL reset_result3: got %h exp 0", res3); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (rdy2 !== 1'b1)      begin n_err++; $display("FAIL reset_ready2: got %b exp 1", rdy2); end
    n_cmp++; if (rdy3 !== 1'b1)      begin n_err++; $display("FAIL reset_ready3: got %b exp 1", rdy3); end
    tick();
  endtask

  task automatic test_arith();
    fu_op        t_op [10];
    logic [63:0] t_a  [10];
    logic [63:0] t_b  [10];
    logic [63:0] t_e  [10];
    t_op[0] = MUL;    t_a[0] = 64'd3;                  t_b[0] = 64'd5;                  t_e[0] = 64'hF;
    t_op[1] = MULHU;  t_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[1] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    t_op[2] = MULH;   t_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[2] = 64'd0;
    t_op[3] = MULHSU; t_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[3] = 64'd2;                  t_e[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_op[4] = MULW;   t_a[4] = 64'h8000_0000;          t_b[4] = 64'd1;                  t_e[4] = 64'hFFFF_FFFF_8000_0000;
    t_op[5] = MULW;   t_a[5] = 64'h1_0000_0003;        t_b[5] = 64'd2;                  t_e[5] = 64'd6;
    t_op[6] = MULHU;  t_a[6] = 64'hFFFF_FFFF_FFFF_FFFE; t_b[6] = 64'd3;                  t_e[6] = 64'd2;
    t_op[7] = MULH;   t_a[7] = 64'hFFFF_FFFF_FFFF_FFFE; t_b[7] = 64'd3;                  t_e[7] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_op[8] = MULHSU; t_a[8] = 64'd2;                  t_b[8] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[8] = 64'd1;
    t_op[9] = MUL;    t_a[9] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[9] = 64'hFFFF_FFFF_FFFF_FFFF; t_e[9] = 64'd1;
    rr2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op2 = t_op[i]; a2 = t_a[i]; b2 = t_b[i]; id2 = 3'(i); v2 = 1'b1;
      #1;
      n_cmp++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL arith_ready[%0d]: got %b exp 1", i, rdy2); end
      tick();
      v2 = 1'b0; op2 = ADD; a2 = 64'd0; b2 = 64'd0;
      n_cmp++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL arith_early[%0d]: got %b exp 0", i, vo2); end
      tick();
      n_cmp++; if (vo2 !== 1'b1)   begin n_err++; $display("FAIL arith_valid[%0d]: got %b exp 1", i, vo2); end
      n_cmp++; if (res2 !== t_e[i]) begin n_err++; $display("FAIL arith_result[%0d]: got %h exp %h", i, res2, t_e[i]); end
      n_cmp++; if (ido2 !== 3'(i)) begin n_err++; $display("FAIL arith_id[%0d]: got %0d exp %0d", i, ido2, i); end
      tick();
      n_cmp++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL arith_once[%0d]: got %b exp 0", i, vo2); end
    end
  endtask

`ifdef MULT_CLMUL_EN
  task automatic test_clmul();
    fu_op        t_op [3];
    logic [63:0] t_a  [3];
    logic [63:0] t_e  [3];
    t_op[0] = CLMUL;  t_a[0] = 64'd3;                  t_e[0] = 64'd5;
    t_op[1] = CLMULH; t_a[1] = 64'h8000_0000_0000_0000; t_e[1] = 64'h4000_0000_0000_0000;
    t_op[2] = CLMULR; t_a[2] = 64'h8000_0000_0000_0000; t_e[2] = 64'h8000_0000_0000_0000;
    rr2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op2 = t_op[i]; a2 = t_a[i]; b2 = t_a[i]; id2 = 3'(i); v2 = 1'b1;
      tick();
      v2 = 1'b0; op2 = ADD;
      tick();
      n_cmp++; if (vo2 !== 1'b1)    begin n_err++; $display("FAIL clmul_valid[%0d]: got %b exp 1", i, vo2); end
      n_cmp++; if (res2 !== t_e[i]) begin n_err++; $display("FAIL clmul_result[%0d]: got %h exp %h", i, res2, t_e[i]); end
      tick();
    end
  endtask
`endif

  task automatic test_unsupported();
    rr2 = 1'b1; op2 = DIV; a2 = 64'd3; b2 = 64'd5; id2 = 3'd1; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL unsup_div[%0d]: got %b exp 0", c, vo2); end
      tick();
    end
`ifndef MULT_CLMUL_EN
    op2 = CLMUL; a2 = 64'd3; b2 = 64'd3; id2 = 3'd2; v2 = 1'b1;
    tick();
    v2 = 1'b0; op2 = ADD;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL unsup_clmul[%0d]: got %b exp 0", c, vo2); end
      tick();
    end
`endif
  endtask

  task automatic test_back_to_back();
    int m;
    rr2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      v2 = (k < 4); op2 = MUL; id2 = 3'(k); a2 = 64'(k + 2); b2 = 64'd7;
      #1;
      n_cmp++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b exp 1", k, rdy2); end
      tick();
      m = k + 1;
      if (m >= 2 && m <= 5) begin
        n_cmp++; if (vo2 !== 1'b1)          begin n_err++; $display("FAIL b2b_valid[%0d]: got %b exp 1", m, vo2); end
        n_cmp++; if (ido2 !== 3'(m - 2))    begin n_err++; $display("FAIL b2b_id[%0d]: got %0d exp %0d", m, ido2, m - 2); end
        n_cmp++; if (res2 !== 64'(m * 7))   begin n_err++; $display("FAIL b2b_result[%0d]: got %h exp %h", m, res2, 64'(m * 7)); end
      end else begin
        n_cmp++; if (vo2 !== 1'b0)          begin n_err++; $display("FAIL b2b_idle[%0d]: got %b exp 0", m, vo2); end
      end
    end
    v2 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [10:0] rr_t  = 11'b111_1100_0011;
    logic [10:0] rdy_t = 11'b111_1100_0111;
    logic [10:0] vo_t  = 11'b011_1111_1000;
    int          eid [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    int          acc = 0;
    for (int c = 0; c < 11; c++) begin
      rr3 = rr_t[c]; v3 = (c < 7); op3 = MUL; id3 = (c < 3) ? 3'(c) : 3'd3;
      a3 = 64'(id3) + 64'd1; b3 = 64'd10;
      #1;
      n_cmp++; if (rdy3 !== rdy_t[c]) begin n_err++; $display("FAIL bp_ready[%0d]: got %b exp %b", c, rdy3, rdy_t[c]); end
      n_cmp++; if (vo3 !== vo_t[c])   begin n_err++; $display("FAIL bp_valid[%0d]: got %b exp %b", c, vo3, vo_t[c]); end
      if (vo_t[c]) begin
        n_cmp++; if (ido3 !== 3'(eid[c]))           begin n_err++; $display("FAIL bp_id[%0d]: got %0d exp %0d", c, ido3, eid[c]); end
        n_cmp++; if (res3 !== 64'((eid[c] + 1) * 10)) begin n_err++; $display("FAIL bp_result[%0d]: got %h exp %h", c, res3, 64'((eid[c] + 1) * 10)); end
      end
      if (v3 && rdy3) acc++;
      if (c == 5) begin
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepts_full: got %0d exp 3", acc); end
      end
      tick();
    end
    v3 = 1'b0;
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepts_total: got %0d exp 4", acc); end
  endtask

  task automatic test_bubble();
    int          vid [10] = '{0, -1, 1, -1, 2, 3, -1, -1, -1, -1};
    int          eid [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
    logic [9:0]  rdy_t = 10'b11_1101_1111;
    logic [9:0]  vo_t  = 10'b01_1111_1000;
    for (int c = 0; c < 10; c++) begin
      rr3 = (c >= 6); v3 = (vid[c] >= 0); op3 = MUL; id3 = 3'(vid[c]);
      a3 = 64'(vid[c] + 1); b3 = 64'd3;
      #1;
      n_cmp++; if (rdy3 !== rdy_t[c]) begin n_err++; $display("FAIL bub_ready[%0d]: got %b exp %b", c, rdy3, rdy_t[c]); end
      n_cmp++; if (vo3 !== vo_t[c])   begin n_err++; $display("FAIL bub_valid[%0d]: got %b exp %b", c, vo3, vo_t[c]); end
      if (vo_t[c]) begin
        n_cmp++; if (ido3 !== 3'(eid[c]))            begin n_err++; $display("FAIL bub_id[%0d]: got %0d exp %0d", c, ido3, eid[c]); end
        n_cmp++; if (res3 !== 64'((eid[c] + 1) * 3)) begin n_err++; $display("FAIL bub_result[%0d]: got %h exp %h", c, res3, 64'((eid[c] + 1) * 3)); end
      end
      tick();
    end
    v3 = 1'b0;
  endtask

  task automatic test_flush();
    int          vid [10] = '{0, 1, 2, 5, -1, 6, -1, -1, -1, -1};
    logic [9:0]  vo_t  = 10'b01_0000_1000;
    int          eid [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 0};
    rr3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      clr3 = (c == 3); v3 = (vid[c] >= 0); op3 = MUL; id3 = 3'(vid[c]);
      a3 = 64'(vid[c] + 1); b3 = 64'd10;
      #1;
      n_cmp++; if (vo3 !== vo_t[c]) begin n_err++; $display("FAIL flush_valid[%0d]: got %b exp %b", c, vo3, vo_t[c]); end
      if (vo_t[c]) begin
        n_cmp++; if (ido3 !== 3'(eid[c])) begin n_err++; $display("FAIL flush_id[%0d]: got %0d exp %0d", c, ido3, eid[c]); end
      end
      tick();
    end
    clr3 = 1'b0; v3 = 1'b0;
  endtask

  task automatic test_async_reset();
    rr2 = 1'b0; op2 = MUL; a2 = 64'd4; b2 = 64'd4; id2 = 3'd3; v2 = 1'b1;
    tick();
    v2 = 1'b0;
    tick();
    n_cmp++; if (vo2 !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b exp 1", vo2); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (vo2 !== 1'b0)   begin n_err++; $display("FAIL arst_valid: got %b exp 0", vo2); end
    n_cmp++; if (res2 !== 64'd0) begin n_err++; $display("FAIL arst_result: got %h exp 0", res2); end
    rst_n = 1'b1;
    rr2 = 1'b1;
    tick();
    tick();
    n_cmp++; if (vo2 !== 1'b0) begin n_err++; $display("FAIL arst_post_valid: got %b exp 0", vo2); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    clr2 = 1'b0; v2 = 1'b0; rr2 = 1'b1; id2 = 3'd0; op2 = ADD; a2 = 64'd0; b2 = 64'd0;
    clr3 = 1'b0; v3 = 1'b0; rr3 = 1'b1; id3 = 3'd0; op3 = ADD; a3 = 64'd0; b3 = 64'd0;
    test_reset();
    test_arith();
`ifdef MULT_CLMUL_EN
    test_clmul();
`endif
    test_unsupported();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
